// File: rtl/iq_group_issuer_if.sv
// Instruction-in / queue-push bundle for iq_group_issuer.
// master: the issuer (accepts instructions, drives the queue push port).
// slave : the environment (decoder upstream, instruction queue downstream).
interface iq_group_issuer_if #(
  parameter int LOG_SUPERSCALAR_WIDTH = 4,
  parameter int REPEAT_BITS           = 8
);
  // Decoded repeated instruction from upstream
  logic                           in_valid;
  logic                           in_ready;
  logic [1:0]                     in_instr_type;
  logic [REPEAT_BITS-1:0]         in_repeat;
  logic [10:0]                    in_cache_addr;
  logic [10:0]                    in_d_cache_addr;
  logic [6:0]                     in_main_mem_addr;
  logic [6:0]                     in_d_main_mem_addr;
  logic [8:0]                     in_arith_instr;
  logic [2:0]                     in_ram_instr;
  logic [6:0]                     in_ld_st_instr;

  // Push port and refresh control of the instruction queue
  logic                           iq_we;
  logic [1:0]                     iq_instr_type;
  logic [LOG_SUPERSCALAR_WIDTH:0] iq_copy_count;
  logic [10:0]                    iq_cache_addr;
  logic [10:0]                    iq_d_cache_addr;
  logic [6:0]                     iq_main_mem_addr;
  logic [6:0]                     iq_d_main_mem_addr;
  logic [8:0]                     iq_arith_instr;
  logic [2:0]                     iq_ram_instr;
  logic [6:0]                     iq_ld_st_instr;
  logic                           iq_needs_reset;
  logic                           iq_empty;
  logic                           iq_reset;

  modport master (
    input  in_valid, in_instr_type, in_repeat,
           in_cache_addr, in_d_cache_addr, in_main_mem_addr, in_d_main_mem_addr,
           in_arith_instr, in_ram_instr, in_ld_st_instr,
           iq_needs_reset, iq_empty,
    output in_ready,
           iq_we, iq_instr_type, iq_copy_count,
           iq_cache_addr, iq_d_cache_addr, iq_main_mem_addr, iq_d_main_mem_addr,
           iq_arith_instr, iq_ram_instr, iq_ld_st_instr, iq_reset
  );

  modport slave (
    output in_valid, in_instr_type, in_repeat,
           in_cache_addr, in_d_cache_addr, in_main_mem_addr, in_d_main_mem_addr,
           in_arith_instr, in_ram_instr, in_ld_st_instr,
           iq_needs_reset, iq_empty,
    input  in_ready,
           iq_we, iq_instr_type, iq_copy_count,
           iq_cache_addr, iq_d_cache_addr, iq_main_mem_addr, iq_d_main_mem_addr,
           iq_arith_instr, iq_ram_instr, iq_ld_st_instr, iq_reset
  );
endinterface

// File: rtl/iq_group_issuer.sv
// iq_group_issuer: splits one repeated instruction into superscalar groups of
// at most SUPERSCALAR_WIDTH copies, pushes one group per cycle into the
// instruction queue, and sequences the queue's virtual-position refresh
// (drain, then a one-cycle iq_reset pulse) whenever the queue requests it.
// Optional build macro IQ_ISSUER_PERF_EN adds saturating perf counters
// perf_groups and perf_drain_cycles.
module iq_group_issuer #(
  parameter int SUPERSCALAR_WIDTH     = 16,
  parameter int LOG_SUPERSCALAR_WIDTH = 4,
  parameter int REPEAT_BITS           = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  iq_group_issuer_if.master    bus,
  output logic                 busy
`ifdef IQ_ISSUER_PERF_EN
  ,
  output logic [31:0]          perf_groups,
  output logic [31:0]          perf_drain_cycles
`endif
);

  localparam int CNT_W = LOG_SUPERSCALAR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESET_IQ
  } state_t;

  state_t                 state;
  state_t                 state_n;

  // Held instruction: remaining copies, running bases and constant fields
  logic [REPEAT_BITS-1:0] remaining;
  logic [10:0]            cache_base;
  logic [6:0]             main_base;
  logic [1:0]             lat_instr_type;
  logic [10:0]            lat_d_cache_addr;
  logic [6:0]             lat_d_main_mem_addr;
  logic [8:0]             lat_arith_instr;
  logic [2:0]             lat_ram_instr;
  logic [6:0]             lat_ld_st_instr;

  logic [CNT_W-1:0]       copy_count;
  logic                   take_instr;
  logic                   instr_ok;
  logic                   do_push;

  // NOTE: in_ready depends only on state and the queue's refresh request, so
  // upstream never sees a combinational path from its own in_valid.
  assign bus.in_ready = (state == IDLE) && !bus.iq_needs_reset;

  // Next-state and push decision for the current cycle
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    state_n    = state;
    do_push    = 1'b0;
    take_instr = (state == IDLE) && !bus.iq_needs_reset && bus.in_valid;
    instr_ok   = (bus.in_repeat != '0) && (bus.in_instr_type != 2'd3);
    if (remaining >= REPEAT_BITS'(SUPERSCALAR_WIDTH)) begin
      copy_count = CNT_W'(SUPERSCALAR_WIDTH);
    end else begin
      copy_count = CNT_W'(remaining);
    end

    case (state)
      IDLE: begin
        if (bus.iq_needs_reset) begin
          state_n = DRAIN;
        end else if (bus.in_valid && instr_ok) begin
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        // A refresh request holds the pending group until after RESET_IQ
        if (bus.iq_needs_reset) begin
          state_n = DRAIN;
        end else begin
          do_push = 1'b1;
          if (remaining == REPEAT_BITS'(copy_count)) begin
            state_n = IDLE;
          end
        end
      end
      DRAIN: begin
        if (bus.iq_empty) begin
          state_n = RESET_IQ;
        end
      end
      RESET_IQ: begin
        state_n = (remaining != '0) ? ISSUE : IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, held instruction and registered queue-side outputs
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (reset) begin
      state                  <= IDLE;
      busy                   <= 1'b0;
      remaining              <= '0;
      cache_base             <= '0;
      main_base              <= '0;
      lat_instr_type         <= '0;
      lat_d_cache_addr       <= '0;
      lat_d_main_mem_addr    <= '0;
      lat_arith_instr        <= '0;
      lat_ram_instr          <= '0;
      lat_ld_st_instr        <= '0;
      bus.iq_we              <= 1'b0;
      bus.iq_reset           <= 1'b0;
      bus.iq_instr_type      <= '0;
      bus.iq_copy_count      <= '0;
      bus.iq_cache_addr      <= '0;
      bus.iq_d_cache_addr    <= '0;
      bus.iq_main_mem_addr   <= '0;
      bus.iq_d_main_mem_addr <= '0;
      bus.iq_arith_instr     <= '0;
      bus.iq_ram_instr       <= '0;
      bus.iq_ld_st_instr     <= '0;
    end else begin
      state        <= state_n;
      busy         <= (state_n != IDLE);
      bus.iq_we    <= do_push;
      bus.iq_reset <= (state_n == RESET_IQ);

      if (take_instr) begin
        // A discarded instruction leaves nothing pending for a later refresh
        remaining           <= instr_ok ? bus.in_repeat : '0;
        cache_base          <= bus.in_cache_addr;
        main_base           <= bus.in_main_mem_addr;
        lat_instr_type      <= bus.in_instr_type;
        lat_d_cache_addr    <= bus.in_d_cache_addr;
        lat_d_main_mem_addr <= bus.in_d_main_mem_addr;
        lat_arith_instr     <= bus.in_arith_instr;
        lat_ram_instr       <= bus.in_ram_instr;
        lat_ld_st_instr     <= bus.in_ld_st_instr;
      end

      if (do_push) begin
        bus.iq_instr_type      <= lat_instr_type;
        bus.iq_copy_count      <= copy_count;
        bus.iq_cache_addr      <= cache_base;
        bus.iq_d_cache_addr    <= lat_d_cache_addr;
        bus.iq_main_mem_addr   <= main_base;
        bus.iq_d_main_mem_addr <= lat_d_main_mem_addr;
        bus.iq_arith_instr     <= lat_arith_instr;
        bus.iq_ram_instr       <= lat_ram_instr;
        bus.iq_ld_st_instr     <= lat_ld_st_instr;
        // Bases advance by a full group of strides; widths wrap naturally
        remaining  <= remaining - REPEAT_BITS'(copy_count);
        cache_base <= cache_base + (lat_d_cache_addr << LOG_SUPERSCALAR_WIDTH);
        main_base  <= main_base + (lat_d_main_mem_addr << LOG_SUPERSCALAR_WIDTH);
      end
    end
  end

`ifdef IQ_ISSUER_PERF_EN
  // Saturating counters of pushed groups and refresh-sequence cycles
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_groups       <= '0;
      perf_drain_cycles <= '0;
    end else begin
      if (bus.iq_we && (perf_groups != '1)) begin
        perf_groups <= perf_groups + 32'd1;
      end
      if (((state == DRAIN) || (state == RESET_IQ)) && (perf_drain_cycles != '1)) begin
        perf_drain_cycles <= perf_drain_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
